// File: rtl/key_entry_pkg.sv
// Shared types and helpers for the keypad front end.
package key_entry_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBounce,
        StHeld,
        StRelease
    } key_state_e;

    // Helpers take a fixed-width vector. Callers zero-extend their NUM_KEYS-wide value with a
    // size cast, which lets one function serve any keypad width up to MAX_KEYS.
    localparam int unsigned MAX_KEYS = 64;
    typedef logic [MAX_KEYS-1:0] key_vec_t;

    function automatic logic is_one_hot(key_vec_t v);
        return $onehot(v);
    endfunction

    // Returns the position of the set bit; only meaningful for one-hot inputs.
    function automatic int unsigned key_index(key_vec_t v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_KEYS; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_entry_if.sv
// Keypad-side and controller-side signals of the key entry unit.
interface key_entry_if #(
    parameter int unsigned NUM_KEYS = 10,
    parameter int unsigned CODE_W   = $clog2(NUM_KEYS)
);
    logic [NUM_KEYS-1:0] keys;
    logic                mode;
    logic [CODE_W-1:0]   code;
    logic                key_valid;
    logic                load;
    logic                multi_err;
    logic                pulse;

    modport master (
        output keys, mode,
        input  code, key_valid, load, multi_err, pulse
    );

    modport slave (
        input  keys, mode,
        output code, key_valid, load, multi_err, pulse
    );
endinterface

// File: rtl/tick_gen.sv
// Free-running timer tick divider with a synchronous restart.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // Count 0..TICK_DIV-1; the tick register fires on the wrap, restart suppresses it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (restart) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;
endmodule

// File: rtl/key_entry_unit.sv
// Keypad front end: synchronise, debounce, encode, auto-repeat and timer-tick steering.
module key_entry_unit
    import key_entry_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 10,
    parameter int unsigned CODE_W          = $clog2(NUM_KEYS),
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TICK_DIV        = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 0
) (
    input logic        clk,
    input logic        reset,
    key_entry_if.slave bus
);
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RP_W-1:0] RP_MAX = RP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam bit REPEAT_EN = (REPEAT_CYCLES > 0);

    logic [NUM_KEYS-1:0] r_sync1, r_sync2;
    logic [NUM_KEYS-1:0] r_snap, w_snap_next;
    key_state_e          r_state, w_state_next;
    logic [DB_W-1:0]     r_cnt, w_cnt_next;
    logic [RP_W-1:0]     r_rep, w_rep_next;
    logic [CODE_W-1:0]   r_code, w_code_next;
    logic                r_key_valid, w_key_valid_next;
    logic                r_load, w_load_next;
    logic                r_multi_err, w_multi_err_next;
    logic                r_mode;
    logic [NUM_KEYS-1:0] w_keys_s;
    logic                w_snap_one_hot;
    logic                w_restart;
    logic                w_tick;

    assign w_keys_s       = r_sync2;
    assign w_snap_one_hot = is_one_hot(key_vec_t'(r_snap));
    assign w_restart      = bus.mode & ~r_mode;

    // Synchroniser, mode history and all FSM-owned registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_mode      <= 1'b0;
            r_state     <= StIdle;
            r_snap      <= '0;
            r_cnt       <= '0;
            r_rep       <= '0;
            r_code      <= '0;
            r_key_valid <= 1'b0;
            r_load      <= 1'b0;
            r_multi_err <= 1'b0;
        end else begin
            r_sync1     <= bus.keys;
            r_sync2     <= r_sync1;
            r_mode      <= bus.mode;
            r_state     <= w_state_next;
            r_snap      <= w_snap_next;
            r_cnt       <= w_cnt_next;
            r_rep       <= w_rep_next;
            r_code      <= w_code_next;
            r_key_valid <= w_key_valid_next;
            r_load      <= w_load_next;
            r_multi_err <= w_multi_err_next;
        end
    end

    // Debounce FSM with press/release counting and held-key auto-repeat.
    always_comb begin
        w_state_next     = r_state;
        w_snap_next      = r_snap;
        w_cnt_next       = r_cnt;
        w_rep_next       = r_rep;
        w_code_next      = r_code;
        w_load_next      = r_load;
        w_key_valid_next = 1'b0;
        w_multi_err_next = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_keys_s != '0) begin
                    w_snap_next  = w_keys_s;
                    w_cnt_next   = '0;
                    w_state_next = StBounce;
                end
            end
            StBounce: begin
                if (w_keys_s == '0) begin
                    w_state_next = StIdle;
                end else if (w_keys_s != r_snap) begin
                    w_snap_next = w_keys_s;
                    w_cnt_next  = '0;
                end else if (r_cnt == DB_MAX) begin
                    w_state_next = StHeld;
                    w_rep_next   = '0;
                    if (w_snap_one_hot) begin
                        w_code_next      = CODE_W'(key_index(key_vec_t'(r_snap)));
                        w_key_valid_next = 1'b1;
                        w_load_next      = 1'b1;
                    end else begin
                        w_multi_err_next = 1'b1;
                        w_load_next      = 1'b0;
                    end
                end else begin
                    w_cnt_next = r_cnt + DB_W'(1);
                end
            end
            StHeld: begin
                if (w_keys_s == '0) begin
                    w_cnt_next   = '0;
                    w_rep_next   = '0;
                    w_state_next = StRelease;
                end else if (REPEAT_EN && r_load) begin
                    // r_load doubles as "the accepted press was one-hot".
                    if (r_rep == RP_MAX) begin
                        w_rep_next       = '0;
                        w_key_valid_next = 1'b1;
                    end else begin
                        w_rep_next = r_rep + RP_W'(1);
                    end
                end
            end
            StRelease: begin
                if (w_keys_s != '0) begin
                    w_state_next = StHeld;
                end else if (r_cnt == DB_MAX) begin
                    w_state_next = StIdle;
                    w_load_next  = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + DB_W'(1);
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .restart (w_restart),
        .tick    (w_tick)
    );

    assign bus.code      = r_code;
    assign bus.key_valid = r_key_valid;
    assign bus.load      = r_load;
    assign bus.multi_err = r_multi_err;
    assign bus.pulse     = bus.mode ? w_tick : r_key_valid;
endmodule

// File: doc/key_entry_unit.md
# key_entry_unit

Parametrised keypad front end for the microwave controller: synchronises and debounces an N-key one-hot keypad, encodes the accepted key to a binary digit, and generates a divided timer tick. The block replaces the fixed 10-key encoder path. It adds a real reset, multi-key rejection, release debouncing, optional auto-repeat, and a mode-selected output pulse. Output feeds the digit-entry register and countdown logic.

## Interface
- NUM_KEYS, 10, number of key lines (≥2)
- CODE_W, $clog2(NUM_KEYS), width of encoded digit
- DEBOUNCE_CYCLES, 16, stable cycles required for press and release (≥1)
- TICK_DIV, 50_000_000, clk cycles per timer tick (≥2)
- REPEAT_CYCLES, 0, auto-repeat period while a single key is held; 0 disables repeat
- clk  in  1  system clock; the block uses one clock, rising edge only
- reset  in  1  asynchronous reset, active-high
- keys  in  NUM_KEYS  raw key lines, asynchronous, active-high
- mode  in  1  0 = key-entry mode, 1 = timer mode; synchronous to clk
- code  out  CODE_W  index of the last accepted key; holds its value between presses
- key_valid  out  1  one-cycle pulse on each accepted press or repeat
- load  out  1  high while an accepted single key is held (HELD state)
- multi_err  out  1  one-cycle pulse when a debounced press has more than one key set
- pulse  out  1  equals key_valid when mode=0 and tick when mode=1

## Operation
- **Input synchronisation.** keys pass through a 2-flop synchroniser. The synchronised value is keys_s.
- **FSM states.** IDLE, BOUNCE, HELD, RELEASE.
- **IDLE.**
  - keys_s != 0 → capture snap = keys_s, clear cnt, go to BOUNCE.
- **BOUNCE.**
  - keys_s == 0 → go to IDLE.
  - keys_s != snap → set snap = keys_s and clear cnt.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1: on a one-hot snap, set code = index, pulse key_valid, go to HELD. On a non-one-hot snap, pulse multi_err, go to HELD with load = 0. Else increment cnt.
- **HELD.**
  - keys_s == 0 → clear cnt, go to RELEASE.
  - If REPEAT_CYCLES > 0 and the press was one-hot, a repeat counter pulses key_valid every REPEAT_CYCLES cycles in HELD. code is unchanged.
  - Changes in keys_s while in HELD are ignored. No new press is accepted without a full release.
- **RELEASE.**
  - keys_s != 0 → go back to HELD with no new key_valid.
  - Otherwise, once cnt == DEBOUNCE_CYCLES-1, go to IDLE; else increment cnt.
- **load.** load = 1 exactly in HELD following a one-hot accept, and it stays 1 through RELEASE.
- **Tick divider.** A free-running counter runs 0..TICK_DIV-1. tick is a one-cycle pulse at the count value TICK_DIV-1.
- **Tick restart.** On the cycle mode goes 0→1, the divider clears. The first tick therefore arrives exactly TICK_DIV cycles later.
- **Mode independence.** The key FSM runs in both modes. mode only steers pulse.

## Timing
- **Reset values.** code=0, key_valid=0, load=0, multi_err=0, pulse=0. State is IDLE, all counters and synchroniser flops are 0, and snap=0.
- **Press latency.** Count the first rising edge at which a clean press is present on keys as edge 0. key_valid is high for exactly the cycle following edge DEBOUNCE_CYCLES+2. code updates at that same edge.
- **Release latency.** After keys go cleanly to 0, the FSM returns to IDLE at edge DEBOUNCE_CYCLES+2 and load falls at that same edge.
- **Registered outputs.** All outputs except pulse are registered. pulse is a 2:1 mux of registered signals and mode.
- **Simultaneous events.** A repeat and a mode change in the same cycle: key_valid still pulses, and pulse follows the new mode.
- **Reset mid-operation.** Asserting reset at any point forces reset values immediately. No pulse is emitted on deassertion.
- **Wrap-around.** The tick counter wraps TICK_DIV-1→0. The repeat counter wraps to 0 after each repeat.

## Structure
- **Package key_entry_pkg.** Holds the state enum (IDLE, BOUNCE, HELD, RELEASE) and a one-hot-check / index-encode function parametrised on NUM_KEYS.
- **Sub-module tick_gen.** Parameter TICK_DIV. Ports: clk, reset, restart, tick.
- The synchroniser, FSM and repeat counter stay in key_entry_unit.

## Test plan
- **Clean press.** DEBOUNCE_CYCLES=4, keys=10'b0000100000 held for 20 cycles → single key_valid at edge 6, code=5, load=1. After release, load=0 6 edges later.
- **Bounce.** keys toggles between key 3 and 0 every 2 cycles for 10 cycles, then holds key 3 → exactly one key_valid with code=3, timed from the final stable edge.
- **Multi-key.** Keys 2 and 7 pressed together and held → multi_err pulses once, with no key_valid, code unchanged and load=0.
- **Repeat.** REPEAT_CYCLES=20, key 9 held for 70 cycles after accept → key_valid at accept, +20, +40 and +60, with code=9 throughout.
- **Timer.** TICK_DIV=8, mode 0→1 at cycle 100 → pulse at cycles 108, 116 and 124. Switching back to mode=0 leaves pulse tracking key_valid only.
- **Reset mid-press.** reset asserted in BOUNCE and in HELD → all outputs are 0 at once. After release of reset with the key still held, a new full debounce precedes key_valid.
